// File: rtl/watch_disp_pkg.sv
// Shared constants and helpers for the watch display: segment codes, field
// codes, digit positions and the binary-to-BCD split.
package watch_disp_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [5:0] ANODE_OFF = 6'h3F;

  typedef enum logic [1:0] {
    FLD_NONE = 2'b00,
    FLD_HRS  = 2'b01,
    FLD_MIN  = 2'b10,
    FLD_SEC  = 2'b11
  } field_e;

  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HRS_U = 3'd4;
  localparam logic [2:0] DIG_HRS_T = 3'd5;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Six conditional subtract-10 stages cover every 6-bit input without a divider.
  function automatic bcd_t bcd_split(input logic [5:0] v);
    bcd_t       r;
    logic [5:0] rem;
    rem    = v;
    r.tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem    = rem - 6'd10;
        r.tens = r.tens + 4'd1;
      end
    end
    r.units = rem[3:0];
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern, purely combinational.
module seg7_decode
  import watch_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/watch_display.sv
// Six-digit multiplexed HH.MM.SS display driver: prescaled digit scan, per-frame
// time snapshot, BCD split, field blink and registered anode/segment outputs.
module watch_display
  import watch_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hrs,
  input  logic [5:0] mins,
  input  logic [5:0] sec,
  input  logic [1:0] edit_field,
  output logic [5:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [4:0]    hrs_sh_q, hrs_sh_d;
  logic [5:0]    min_sh_q, min_sh_d;
  logic [5:0]    sec_sh_q, sec_sh_d;
  field_e        fld_sh_q, fld_sh_d;
  logic [5:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_start;
  logic [5:0]    field_val;
  logic [5:0]    field_max;
  field_e        field_id;
  bcd_t          split;
  logic [3:0]    digit_bcd;
  logic [6:0]    dec_seg;

  always_comb begin
    tick        = (presc_q == PRESC_LAST);
    frame_start = tick && (digit_q == DIG_HRS_T);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    digit_d     = digit_q;
    frame_d     = frame_q;
    blink_d     = blink_q;
    hrs_sh_d    = hrs_sh_q;
    min_sh_d    = min_sh_q;
    sec_sh_d    = sec_sh_q;
    fld_sh_d    = fld_sh_q;
    if (tick) begin
      digit_d = frame_start ? DIG_SEC_U : digit_q + 3'd1;
    end
    if (frame_start) begin
      hrs_sh_d = hrs;
      min_sh_d = mins;
      sec_sh_d = sec;
      fld_sh_d = field_e'(edit_field);
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Output registers load from next-state values so the new digit and a fresh
  // snapshot appear one cycle after the tick that selected them.
  always_comb begin
    field_val = sec_sh_d;
    field_max = 6'd59;
    field_id  = FLD_SEC;
    case (digit_d)
      DIG_MIN_U, DIG_MIN_T: begin
        field_val = min_sh_d;
        field_id  = FLD_MIN;
      end
      DIG_HRS_U, DIG_HRS_T: begin
        field_val = {1'b0, hrs_sh_d};
        field_max = 6'd23;
        field_id  = FLD_HRS;
      end
      default: ;
    endcase
    split     = bcd_split(field_val);
    digit_bcd = digit_d[0] ? split.tens : split.units;
  end

  seg7_decode u_dec (
    .bcd_i (digit_bcd),
    .seg_o (dec_seg)
  );

  always_comb begin
    anode_d = ~(6'b000001 << digit_d);
    seg_d   = (field_val > field_max) ? SEG_DASH : dec_seg;
    dp_d    = !((digit_d == DIG_MIN_U) || (digit_d == DIG_HRS_U));
    if (blink_d && (fld_sh_d == field_id)) begin
      anode_d = ANODE_OFF;
      seg_d   = SEG_OFF;
      dp_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      digit_q  <= DIG_SEC_U;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      hrs_sh_q <= '0;
      min_sh_q <= '0;
      sec_sh_q <= '0;
      fld_sh_q <= FLD_NONE;
      anode_q  <= ANODE_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      hrs_sh_q <= hrs_sh_d;
      min_sh_q <= min_sh_d;
      sec_sh_q <= sec_sh_d;
      fld_sh_q <= fld_sh_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_watch_display.sv
// Bench for watch_display: two instances (SCAN_DIV=4/BLINK_DIV=2 and 1/1) against
// a count-based behavioural model of the scan, snapshot and blink rules.
`timescale 1ns/100ps
module tb_watch_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] hrs;
  logic [5:0] mins;
  logic [5:0] sec;
  logic [1:0] edit_field;
  logic [5:0] anode0, anode1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [13:0] obs [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  watch_display #(.SCAN_DIV(4), .BLINK_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .hrs(hrs), .mins(mins), .sec(sec),
    .edit_field(edit_field), .anode(anode0), .seg(seg0), .dp(dp0)
  );

  watch_display #(.SCAN_DIV(1), .BLINK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .hrs(hrs), .mins(mins), .sec(sec),
    .edit_field(edit_field), .anode(anode1), .seg(seg1), .dp(dp1)
  );

  always_comb begin
    obs[0] = {anode0, seg0, dp0};
    obs[1] = {anode1, seg1, dp1};
  end

  // Reference model: e = clock edges since reset release; everything else follows
  // from e with plain division.
  int e_m [2];
  int s_m [2] = '{4, 1};
  int b_m [2] = '{2, 1};
  int sh_h [2];
  int sh_m [2];
  int sh_s [2];
  int sh_e [2];
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        e_m[k]  <= 0;
        sh_h[k] <= 0;
        sh_m[k] <= 0;
        sh_s[k] <= 0;
        sh_e[k] <= 0;
      end else begin
        e_m[k] <= e_m[k] + 1;
        if (((e_m[k] + 1) % s_m[k]) == 0 && (((e_m[k] + 1) / s_m[k]) % 6) == 0) begin
          sh_h[k] <= int'(hrs);
          sh_m[k] <= int'(mins);
          sh_s[k] <= int'(sec);
          sh_e[k] <= int'(edit_field);
        end
      end
    end
  end

  function automatic logic [13:0] model_out(int k);
    int t, d, f, ph, v, lim, code, dig;
    logic [5:0] an;
    logic [6:0] sg;
    logic       p;
    if (e_m[k] == 0) return 14'h3FFF;
    t  = e_m[k] / s_m[k];
    d  = t % 6;
    f  = t / 6;
    ph = (f / b_m[k]) % 2;
    if (d / 2 == 0) begin
      v = sh_s[k]; lim = 59; code = 3;
    end else if (d / 2 == 1) begin
      v = sh_m[k]; lim = 59; code = 2;
    end else begin
      v = sh_h[k]; lim = 23; code = 1;
    end
    if (ph == 1 && sh_e[k] == code) return 14'h3FFF;
    dig = (d % 2 == 1) ? v / 10 : v % 10;
    sg  = (v > lim) ? 7'h3F : seg_tab[dig];
    an  = ~(6'b000001 << d);
    p   = !(d == 2 || d == 4);
    return {an, sg, p};
  endfunction

  task automatic test_reset();
    logic [13:0] exp;
    rst = 1'b0; hrs = 5'd0; mins = 6'd0; sec = 6'd0; edit_field = 2'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 14'h3FFF) begin
        errors++;
        $display("FAIL reset dut%0d: got %h expected 3fff", k, obs[k]);
      end
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp = model_out(k);
      checks++;
      if (obs[k] !== exp) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %h expected %h", k, obs[k], exp);
      end
    end
    #4;
  endtask

  task automatic test_basic();
    logic [13:0] exp;
    logic [13:0] frame2 [6] = '{{6'b111110, 7'h78, 1'b1}, {6'b111101, 7'h40, 1'b1},
                                {6'b111011, 7'h12, 1'b0}, {6'b110111, 7'h19, 1'b1},
                                {6'b101111, 7'h30, 1'b0}, {6'b011111, 7'h79, 1'b1}};
    hrs = 5'd13; mins = 6'd45; sec = 6'd7; edit_field = 2'd0;
    repeat (48) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k);
        checks++;
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL basic dut%0d e=%0d: got %h expected %h", k, e_m[k], obs[k], exp);
        end
      end
      if (e_m[0] >= 24 && e_m[0] < 48 && (e_m[0] % 4) == 1) begin
        checks++;
        if (obs[0] !== frame2[(e_m[0] - 24) / 4]) begin
          errors++;
          $display("FAIL basic_frame2 e=%0d: got %h expected %h", e_m[0], obs[0],
                   frame2[(e_m[0] - 24) / 4]);
        end
      end
    end
  endtask

  task automatic test_midframe();
    logic [13:0] exp;
    int guard, ec;
    guard = 0;
    while ((e_m[0] % 24) != 2 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    ec  = e_m[0];
    sec = 6'd8;
    repeat (26) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k);
        checks++;
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL midframe dut%0d e=%0d: got %h expected %h", k, e_m[k], obs[k], exp);
        end
      end
      if (e_m[0] == ec + 1 || e_m[0] == ec + 23) begin
        checks++;
        if (obs[0][7:1] !== ((e_m[0] == ec + 1) ? 7'h78 : 7'h00)) begin
          errors++;
          $display("FAIL midframe_sec e=%0d: got %h expected %h", e_m[0], obs[0][7:1],
                   (e_m[0] == ec + 1) ? 7'h78 : 7'h00);
        end
      end
    end
  endtask

  task automatic test_range();
    logic [13:0] exp;
    logic [6:0]  want;
    int fs, d;
    hrs = 5'd24; mins = 6'd60; sec = 6'd59;
    fs = ((e_m[0] / 24) + 1) * 24;
    repeat (48) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k);
        checks++;
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL range dut%0d e=%0d: got %h expected %h", k, e_m[k], obs[k], exp);
        end
      end
      if (e_m[0] >= fs) begin
        d    = (e_m[0] / 4) % 6;
        want = (d >= 2) ? 7'h3F : ((d == 1) ? 7'h12 : 7'h10);
        checks++;
        if (obs[0][7:1] !== want) begin
          errors++;
          $display("FAIL range_seg e=%0d digit=%0d: got %h expected %h", e_m[0], d,
                   obs[0][7:1], want);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [13:0] exp;
    int d, fr;
    logic blank;
    @(negedge clk);
    rst = 1'b0;
    hrs = 5'd13; mins = 6'd45; sec = 6'd7; edit_field = 2'b10;
    @(negedge clk);
    rst = 1'b1;
    repeat (192) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k);
        checks++;
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL blink dut%0d e=%0d: got %h expected %h", k, e_m[k], obs[k], exp);
        end
      end
      d  = (e_m[0] / 4) % 6;
      fr = e_m[0] / 24 + 1;
      if (fr <= 8) begin
        blank = (d == 2 || d == 3) && (fr == 3 || fr == 4 || fr == 7 || fr == 8);
        checks++;
        if (obs[0][8 + d] !== blank || (blank && obs[0][7:1] !== 7'h7F)) begin
          errors++;
          $display("FAIL blink_frame fr=%0d digit=%0d: got %h expected blank=%0d", fr, d,
                   obs[0], blank);
        end
      end
    end
  endtask

  task automatic test_fast();
    logic [13:0] exp;
    logic [5:0]  want;
    edit_field = 2'b00;
    repeat (24) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k);
        checks++;
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL fast dut%0d e=%0d: got %h expected %h", k, e_m[k], obs[k], exp);
        end
      end
      want = ~(6'b000001 << (e_m[1] % 6));
      checks++;
      if (obs[1][13:8] !== want) begin
        errors++;
        $display("FAIL fast_walk e=%0d: got %b expected %b", e_m[1], obs[1][13:8], want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] exp;
    hrs = 5'd22; mins = 6'd33; sec = 6'd44;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #0.5;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 14'h3FFF) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h expected 3fff", k, obs[k]);
      end
    end
    #0.5;
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k);
        checks++;
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL after_reset dut%0d e=%0d: got %h expected %h", k, e_m[k], obs[k], exp);
        end
      end
      if (e_m[0] >= 1 && e_m[0] < 24) begin
        checks++;
        if (obs[0][7:1] !== 7'h40) begin
          errors++;
          $display("FAIL after_reset_zero e=%0d: got %h expected 40", e_m[0], obs[0][7:1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] exp;
    repeat (400) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp = model_out(k);
        checks++;
        if (obs[k] !== exp) begin
          errors++;
          $display("FAIL random dut%0d e=%0d: got %h expected %h", k, e_m[k], obs[k], exp);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        hrs        = 5'($urandom_range(0, 31));
        mins       = 6'($urandom_range(0, 63));
        sec        = 6'($urandom_range(0, 63));
        edit_field = 2'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_range();
    test_blink();
    test_fast();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
